// File: rtl/emg_pkg.sv
// Constants and state type for the EMG acquisition path.
// The sequencer and the receive side both use these.
package emg_pkg;

    localparam int EMG_NUM_CH        = 16;
    localparam int EMG_ADC_BITS      = 10;
    localparam int EMG_ADC_CLK_CYCLE = 15;
    localparam int EMG_CH_W          = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        TAIL
    } emg_rx_state_t;

endpackage

// File: rtl/emg_rx_out_reg.sv
// One-entry valid/ready holding register for assembled EMG samples.
// A load that finds the entry occupied and not draining is dropped and flagged.
module emg_rx_out_reg
    import emg_pkg::*;
#(
    parameter int NUM_CH   = EMG_NUM_CH,
    parameter int ADC_BITS = EMG_ADC_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [ADC_BITS-1:0] load_data,
    input  logic [EMG_CH_W-1:0] load_ch,
    input  logic                ready,
    input  logic                clr_flags,
    output logic [ADC_BITS-1:0] out_data,
    output logic [EMG_CH_W-1:0] out_ch,
    output logic                out_frame_end,
    output logic                out_valid,
    output logic                err_overflow
);

    logic [ADC_BITS-1:0] data_reg, data_next;
    logic [EMG_CH_W-1:0] ch_reg, ch_next;
    logic                fe_reg, fe_next;
    logic                valid_reg, valid_next;
    logic                ovf_reg, ovf_next;
    logic                accept;

    always_comb begin
        data_next  = data_reg;
        ch_next    = ch_reg;
        fe_next    = fe_reg;
        valid_next = valid_reg;
        // A load is taken if the slot is empty or being drained on this same edge
        accept     = load && (!valid_reg || ready);
        if (accept) begin
            data_next  = load_data;
            ch_next    = load_ch;
            fe_next    = (load_ch == EMG_CH_W'(NUM_CH - 1));
            valid_next = 1'b1;
        end else if (ready) begin
            valid_next = 1'b0;
        end
        ovf_next = (load && !accept) || (ovf_reg && !clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            ch_reg    <= '0;
            fe_reg    <= 1'b0;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            data_reg  <= data_next;
            ch_reg    <= ch_next;
            fe_reg    <= fe_next;
            valid_reg <= valid_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign out_data      = data_reg;
    assign out_ch        = ch_reg;
    assign out_frame_end = fe_reg;
    assign out_valid     = valid_reg;
    assign err_overflow  = ovf_reg;

endmodule

// File: rtl/emg_adc_sample_receiver.sv
// Captures the SAR ADC's MSB-first serial result for each EMG conversion
// and hands the channel-tagged sample to the packetiser over valid/ready.
module emg_adc_sample_receiver
    import emg_pkg::*;
#(
    parameter int NUM_CH        = EMG_NUM_CH,
    parameter int ADC_BITS      = EMG_ADC_BITS,
    parameter int ADC_CLK_CYCLE = EMG_ADC_CLK_CYCLE,
    parameter int FIRST_BIT     = 2
) (
    input  logic                CLK_EMG,
    input  logic                RESET,
    input  logic                EN_ADC_EMG,
    input  logic                START_EMG,
    input  logic [EMG_CH_W-1:0] CH_SEL_EMG,
    input  logic                ADC_DOUT,
    input  logic                CLR_FLAGS,
    output logic [ADC_BITS-1:0] OUT_DATA,
    output logic [EMG_CH_W-1:0] OUT_CH,
    output logic                OUT_FRAME_END,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic                BUSY,
    output logic                ERR_START,
    output logic                ERR_OVERFLOW
);

    localparam int CNT_W = $clog2(ADC_CLK_CYCLE);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(FIRST_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LSB  = CNT_W'(FIRST_BIT + ADC_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FIRST_BIT + ADC_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADC_CLK_CYCLE - 1);

    emg_rx_state_t       state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
    logic [ADC_BITS-1:0] shreg_reg, shreg_next;
    logic [EMG_CH_W-1:0] ch_q_reg, ch_q_next;
    logic                err_start_reg, err_start_next;
    logic                busy;
    logic                load;

    assign busy = (state_reg != IDLE);
    // cnt_inc is the conversion cycle number of the current edge
    assign cnt_inc = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shreg_next     = shreg_reg;
        ch_q_next      = ch_q_reg;
        load           = 1'b0;
        err_start_next = (busy && START_EMG) || (err_start_reg && !CLR_FLAGS);

        if (state_reg == IDLE) begin
            if (START_EMG && EN_ADC_EMG) begin
                ch_q_next  = CH_SEL_EMG;
                cnt_next   = '0;
                state_next = (FIRST_BIT == 1) ? SHIFT : WAIT;
            end
        end else if (!EN_ADC_EMG) begin
            state_next = IDLE;
        end else begin
            cnt_next = cnt_inc;
            case (state_reg)
                WAIT: begin
                    if (cnt_inc == CNT_PRE) state_next = SHIFT;
                end
                SHIFT: begin
                    shreg_next = {shreg_reg[ADC_BITS-2:0], ADC_DOUT};
                    if (cnt_inc == CNT_LSB) state_next = TAIL;
                end
                TAIL: begin
                    load = (cnt_inc == CNT_LOAD);
                    if (cnt_inc == CNT_LAST) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_EMG or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            ch_q_reg      <= '0;
            err_start_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shreg_reg     <= shreg_next;
            ch_q_reg      <= ch_q_next;
            err_start_reg <= err_start_next;
        end
    end

    emg_rx_out_reg #(
        .NUM_CH   (NUM_CH),
        .ADC_BITS (ADC_BITS)
    ) u_out_reg (
        .clk           (CLK_EMG),
        .rst_n         (RESET),
        .load          (load),
        .load_data     (shreg_reg),
        .load_ch       (ch_q_reg),
        .ready         (OUT_READY),
        .clr_flags     (CLR_FLAGS),
        .out_data      (OUT_DATA),
        .out_ch        (OUT_CH),
        .out_frame_end (OUT_FRAME_END),
        .out_valid     (OUT_VALID),
        .err_overflow  (ERR_OVERFLOW)
    );

    assign BUSY      = busy;
    assign ERR_START = err_start_reg;

endmodule

// File: tb/tb_emg_adc_sample_receiver.sv
// Self-checking bench: each conversion is tracked as a transaction (start cycle,
// intended word, channel) and the expected output register follows the handshake rules.
module tb_emg_adc_sample_receiver;
    import emg_pkg::*;

    localparam int FB  = 2;
    localparam int AB  = EMG_ADC_BITS;
    localparam int ACC = EMG_ADC_CLK_CYCLE;
    localparam int NCH = EMG_NUM_CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, start = 1'b0, dout = 1'b0, clr = 1'b0, rdy = 1'b0;
    logic [3:0]    ch_sel = '0;
    logic [AB-1:0] out_data;
    logic [3:0]    out_ch;
    logic          out_fe, out_valid, busy, err_start, err_ovf;

    int checks = 0;
    int failures = 0;

    // transaction-level model state
    bit            m_busy, m_valid, m_errs, m_ovf;
    int            m_k;
    logic [AB-1:0] m_word, m_dout;
    logic [3:0]    m_ch, m_cho;

    emg_adc_sample_receiver #(
        .NUM_CH (NCH), .ADC_BITS (AB), .ADC_CLK_CYCLE (ACC), .FIRST_BIT (FB)
    ) dut (
        .CLK_EMG (clk), .RESET (rst_n), .EN_ADC_EMG (en), .START_EMG (start),
        .CH_SEL_EMG (ch_sel), .ADC_DOUT (dout), .CLR_FLAGS (clr),
        .OUT_DATA (out_data), .OUT_CH (out_ch), .OUT_FRAME_END (out_fe),
        .OUT_VALID (out_valid), .OUT_READY (rdy), .BUSY (busy),
        .ERR_START (err_start), .ERR_OVERFLOW (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("valid",     32'(out_valid), 32'(m_valid));
        check("data",      32'(out_data),  32'(m_dout));
        check("ch",        32'(out_ch),    32'(m_cho));
        check("frame_end", 32'(out_fe),    32'(m_cho == 4'(NCH - 1)));
        check("busy",      32'(busy),      32'(m_busy));
        check("err_start", 32'(err_start), 32'(m_errs));
        check("err_ovf",   32'(err_ovf),   32'(m_ovf));
    endtask

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_errs = 0; m_ovf = 0; m_k = 0;
        m_word = '0; m_dout = '0; m_ch = '0; m_cho = '0;
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, compare 1ns later
    task automatic cyc(input bit s, input bit e, input logic [3:0] c, input bit r,
                       input bit cl, input logic [AB-1:0] w);
        int kn;
        bit ld, es, os;
        @(negedge clk);
        start = s; en = e; ch_sel = c; rdy = r; clr = cl;
        kn = m_k + 1;
        if (m_busy && kn >= FB && kn < FB + AB) dout = m_word[AB-1-(kn-FB)];
        else dout = 1'($urandom);
        @(posedge clk);
        ld = 0; es = 0; os = 0;
        if (m_busy) begin
            es = s;
            if (!e) m_busy = 0;
            else begin
                m_k++;
                if (m_k == FB + AB) ld = 1;
                if (m_k == ACC - 1) m_busy = 0;
            end
        end else if (s && e) begin
            m_busy = 1; m_k = 0; m_word = w; m_ch = c;
        end
        if (ld && m_valid && !r) os = 1;
        else if (ld) begin m_valid = 1; m_dout = m_word; m_cho = m_ch; end
        else if (r) m_valid = 0;
        m_errs = es || (m_errs && !cl);
        m_ovf  = os || (m_ovf && !cl);
        #1;
        check_all();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_data"},  32'(out_data),  0);
        check({tag, "_ch"},    32'(out_ch),    0);
        check({tag, "_fe"},    32'(out_fe),    0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_errs"},  32'(err_start), 0);
        check({tag, "_ovf"},   32'(err_ovf),   0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_async");
        model_reset();
        start = 0; clr = 0; rdy = 0; en = 1;
        @(posedge clk);
        #1 check_all();
        rst_n = 1'b1;
    endtask

    task automatic conversion(input logic [3:0] c, input logic [AB-1:0] w, input bit r);
        cyc(1, 1, c, r, 0, w);
        for (int j = 1; j < ACC; j++) cyc(0, 1, 0, r, 0, '0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("rst_init");
        rst_n = 1'b1;

        // single conversion, ch 5, 0x2A5; ready raised at cycle 13
        cyc(1, 1, 5, 0, 0, 10'h2A5);
        for (int j = 1; j < ACC; j++) begin
            cyc(0, 1, 0, j == 13, 0, '0);
            if (j == 11) check("lat_early", 32'(out_valid), 0);
            if (j == 12) begin
                check("lat_valid", 32'(out_valid), 1);
                check("lat_data",  32'(out_data), 32'h2A5);
                check("lat_ch",    32'(out_ch), 5);
                check("lat_fe",    32'(out_fe), 0);
            end
            if (j == 13) check("lat_clear", 32'(out_valid), 0);
        end

        // full frame, back-to-back, ready high
        for (int c = 0; c < NCH; c++) begin
            cyc(1, 1, 4'(c), 1, 0, AB'($urandom));
            for (int j = 1; j < ACC; j++) begin
                cyc(0, 1, 0, 1, 0, '0);
                if (j == 12) begin
                    check("frame_ch", 32'(out_ch), 32'(c));
                    check("frame_fe", 32'(out_fe), 32'(c == NCH - 1));
                end
            end
        end
        check("frame_errs", 32'(err_start), 0);
        check("frame_ovf",  32'(err_ovf), 0);

        // overflow with ready held low
        conversion(3, 10'h001, 0);
        conversion(4, 10'h3FF, 0);
        check("ovf_data", 32'(out_data), 32'h001);
        check("ovf_flag", 32'(err_ovf), 1);
        cyc(0, 1, 0, 1, 1, '0);
        check("ovf_clr", 32'(err_ovf), 0);

        // stray START at cycle 6
        cyc(1, 1, 7, 1, 0, AB'($urandom));
        for (int j = 1; j < ACC; j++) begin
            cyc(j == 6, 1, 9, 1, 0, AB'($urandom));
            if (j == 12) check("sterr_ch", 32'(out_ch), 7);
        end
        check("sterr_flag", 32'(err_start), 1);
        cyc(0, 1, 0, 1, 1, '0);

        // enable dropped at cycle 8
        cyc(1, 1, 2, 1, 0, AB'($urandom));
        for (int j = 1; j < ACC; j++) begin
            cyc(0, j != 8, 0, 1, 0, '0);
            if (j == 8) check("abort_busy", 32'(busy), 0);
        end
        check("abort_novalid", 32'(out_valid), 0);
        cyc(0, 1, 0, 1, 0, '0);
        conversion(12, 10'h155, 1);

        // reset at cycle 9 with a sample held
        conversion(1, 10'h0F0, 0);
        cyc(1, 1, 6, 0, 0, 10'h333);
        for (int j = 1; j < 9; j++) cyc(0, 1, 0, 0, 0, '0);
        async_reset();
        cyc(1, 1, 11, 1, 0, 10'h2C3);
        for (int j = 1; j < ACC; j++) begin
            cyc(0, 1, 0, 1, 0, '0);
            if (j == 12) check("post_rst_data", 32'(out_data), 32'h2C3);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 699) == 0) async_reset();
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 49) != 0, 4'($urandom),
                1'($urandom), $urandom_range(0, 24) == 0, AB'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emg_adc_sample_receiver.md
# emg_adc_sample_receiver

Receive side of the EMG acquisition path. The EMG sequencer drives EN_ADC_EMG, START_EMG and CH_SEL_EMG to the on-chip SAR ADC; this block captures the ADC's serial, MSB-first result bits on the same ADC clock. It assembles each bit stream into a parallel sample tagged with its channel and presents it on a valid/ready port to the downstream packetiser. Protocol errors are reported as sticky flags.

## Interface
Parameters:
- NUM_CH, 16, EMG channels per frame; CH_SEL width is 4 bits (supports NUM_CH ≤ 16)
- ADC_BITS, 10, sample resolution
- ADC_CLK_CYCLE, 15, ADC clock cycles per conversion, counted from the START edge
- FIRST_BIT, 2, conversion cycle on which the MSB is valid; FIRST_BIT + ADC_BITS ≤ ADC_CLK_CYCLE − 1

Ports:
- CLK_EMG  in  1  ADC clock; the same net as ADC_CLK_EMG; all logic on the rising edge
- RESET  in  1  asynchronous, active-low reset
- EN_ADC_EMG  in  1  ADC enable from the sequencer
- START_EMG  in  1  conversion-start pulse, one cycle wide
- CH_SEL_EMG  in  4  channel being converted; valid in the START cycle
- ADC_DOUT  in  1  serial result bit
- CLR_FLAGS  in  1  synchronous clear for the sticky flags
- OUT_DATA  out  ADC_BITS  captured sample
- OUT_CH  out  4  channel tag for OUT_DATA
- OUT_FRAME_END  out  1  high when OUT_CH == NUM_CH−1
- OUT_VALID  out  1  a sample is held on the output
- OUT_READY  in  1  downstream accepts the sample
- BUSY  out  1  a conversion is in progress
- ERR_START  out  1  sticky: a START_EMG arrived while BUSY was high
- ERR_OVERFLOW  out  1  sticky: a sample was dropped because the output was full

## Operation
- States: IDLE, WAIT, SHIFT, TAIL. A 4-bit cycle counter cnt counts conversion cycles; the START edge is cycle 0.
- IDLE → WAIT when START_EMG=1 and EN_ADC_EMG=1 at a clock edge.
  - CH_SEL_EMG is latched into ch_q on that edge.
  - cnt is cleared to 0; BUSY is set.
  - If FIRST_BIT=1, the block goes directly IDLE → SHIFT on this edge.
- WAIT → SHIFT on the edge where cnt reaches FIRST_BIT−1.
- SHIFT captures ADC_DOUT on each edge with cnt = FIRST_BIT … FIRST_BIT+ADC_BITS−1.
  - Bits are shifted left into shreg, so the MSB arrives first.
  - After the LSB edge the state moves to TAIL.
- TAIL, on its first cycle (cnt = FIRST_BIT+ADC_BITS), performs the output load described below.
  - TAIL then waits until cnt = ADC_CLK_CYCLE−1, returns to IDLE, and clears BUSY on that edge.
- Output load:
  - If OUT_VALID=0, or OUT_VALID=1 with OUT_READY=1 on the same edge: OUT_DATA←shreg, OUT_CH←ch_q, OUT_FRAME_END←(ch_q==NUM_CH−1), OUT_VALID←1.
  - Otherwise the new sample is discarded, ERR_OVERFLOW←1, and the held sample is kept unchanged.
- Handshake:
  - OUT_VALID and the output data stay stable until an edge with OUT_READY=1; that edge clears OUT_VALID unless a load happens on the same edge.
  - OUT_READY is ignored while OUT_VALID=0.
- START_EMG while BUSY=1: the pulse is ignored and ERR_START←1. The conversion in progress continues.
- EN_ADC_EMG=0 while BUSY=1: the conversion is aborted on that edge.
  - The state returns to IDLE and BUSY←0; no sample is loaded.
  - OUT_VALID and its data are not affected.
- CLR_FLAGS=1 clears both sticky flags.
  - If a flag's set condition occurs on the same edge, the set wins.
- cnt saturates at ADC_CLK_CYCLE−1; it never wraps.

## Timing
- Reset values: every output 0, state IDLE, cnt 0, shreg 0, ch_q 0. Reset may be asserted at any point, including mid-conversion or with OUT_VALID high, and the block recovers cleanly.
- Latency: OUT_VALID rises on the edge at cycle FIRST_BIT+ADC_BITS, i.e. cycle 12 with the default parameters.
- Back-to-back conversions: the earliest accepted next START is at cycle ADC_CLK_CYCLE after the previous START edge. With the defaults this is cycle 15, which matches the sequencer's continuous 15-cycle cadence.
- Throughput: one sample per ADC_CLK_CYCLE cycles.
  - OUT_READY may stay low for up to ADC_CLK_CYCLE−1 cycles after OUT_VALID rises without loss.
  - If it stays low through the next load edge, that next sample is dropped.

## Structure
- Shared package emg_pkg holds:
  - the state enum emg_rx_state_t (IDLE, WAIT, SHIFT, TAIL);
  - the constants EMG_NUM_CH, EMG_ADC_BITS, EMG_ADC_CLK_CYCLE, EMG_CH_W=4. The sequencer uses the same constants.
- One sub-module, emg_rx_out_reg, implements the one-entry valid/ready holding register and the overflow detection. The FSM, counter and shift register live in the top module.

## Test plan
- Single conversion, CH_SEL=5, ADC_DOUT drives 10'h2A5 MSB-first on cycles 2–11 → OUT_VALID rises at cycle 12 with OUT_DATA=10'h2A5, OUT_CH=5, OUT_FRAME_END=0; OUT_VALID clears one cycle after OUT_READY=1.
- Full frame of 16 channels back-to-back, 15 cycles apart, OUT_READY tied high → 16 samples in channel order 0–15, with OUT_FRAME_END=1 only on channel 15 and no flags set.
- OUT_READY held low across two conversions (data 10'h001, then 10'h3FF) → output keeps 10'h001, ERR_OVERFLOW=1; CLR_FLAGS clears the flag.
- START_EMG pulsed at cycle 6 of a conversion → ERR_START=1 and the original sample still completes with its original channel.
- EN_ADC_EMG dropped at cycle 8 → BUSY=0 on the next edge, no OUT_VALID; the next START at any later cycle converts normally.
- RESET asserted at cycle 9 with OUT_VALID=1 from an earlier sample → all outputs are 0 immediately (asynchronously); the first conversion after reset release is correct.
